nl2_scm_dbank_sram_ctrl: RTL and testbench
==========================================

Name: nl2_scm_dbank_sram_ctrl

Overview:
Access sequencer directly upstream of the SCM data-bank SRAM array. It accepts single read/write requests over a valid/ready handshake and registers them onto the array's shared address, data and mask buses. It decodes the target bank into one-hot per-bank read/write/clock enables and returns read data through a credit-protected response FIFO. It also sequences the array's sd/ds power controls with drain and wake-up timing.

Parameters:
ADDR_SIZE, 10, row address width
DATA_WIDTH, 8, SRAM word width including ECC bits
MASK_WIDTH, 1, mask bits per narrow lane
N_NARROW, 4, narrow lanes per word
N_SRAM, 4, number of SRAM banks (1..8)
RD_LAT, 1, SRAM read latency in cycles (1 or 2)
WAKE_CYC, 4, idle cycles after sd/ds release before accesses (>=1)

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1 = write, 0 = read
req_bank  in  max(1,$clog2(N_SRAM))  target bank
req_addr  in  ADDR_SIZE  row address
req_data  in  DATA_WIDTH  write data
req_mask  in  N_NARROW*MASK_WIDTH  write lane enables, flattened, lane 0 in LSBs
rsp_valid  out  1  read data valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  DATA_WIDTH  read data
pwr_sd_req  in  1  shutdown request, level
pwr_ds_req  in  1  deep-sleep request, level
pwr_ack  out  1  array is in the requested low-power state
sram_ck_en  out  N_SRAM  per-bank clock enable
sram_sd  out  1  array shutdown
sram_ds  out  1  array deep sleep
sram_addr  out  ADDR_SIZE  registered address
sram_data_wr  out  DATA_WIDTH  registered write data
sram_mask  out  N_NARROW*MASK_WIDTH  registered mask
sram_read_en  out  N_SRAM  one-hot read enable
sram_wrte_en  out  N_SRAM  one-hot write enable
sram_data_rd  in  N_SRAM*DATA_WIDTH  per-bank read data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset: all outputs 0; state WAKE; wake counter = WAKE_CYC; FIFO empty; inflight count 0.
- States:
  - ACTIVE: requests accepted.
  - DRAIN: no accepts; waits for inflight reads to reach 0.
  - SLEEP: sram_sd = pwr_sd_req, sram_ds = pwr_ds_req (registered); pwr_ack = 1.
  - WAKE: sd/ds = 0; counter decrements to 0.
- Transitions:
  - ACTIVE -> DRAIN when (pwr_sd_req|pwr_ds_req).
  - DRAIN -> SLEEP when inflight == 0.
  - SLEEP -> WAKE when both requests are 0.
  - WAKE -> ACTIVE when counter == 1; counter reloads on WAKE entry.
  - In DRAIN, dropping both requests returns to ACTIVE directly.
- req_ready = (state == ACTIVE) & (fifo_count + inflight < RD_LAT+2). There is no combinational path from rsp_ready or req_valid to req_ready.
- Access timing, request accepted at edge E:
  - Cycle E..E+1 drives sram_addr/data_wr/mask, sram_ck_en[bank] = 1, and exactly one of read_en/wrte_en[bank] = 1.
  - With no accept, all enables are 0; addr/data/mask hold their previous values.
- Reads: bank index is piped RD_LAT stages. sram_data_rd of that bank is captured into the FIFO at edge E+1+RD_LAT. rsp_valid is asserted from that edge, so latency is RD_LAT+1 cycles. Back-to-back reads sustain 1 per cycle with rsp_ready held high.
- FIFO depth is RD_LAT+2. Push and pop in the same cycle are both legal. Push never finds the FIFO full (credit rule guarantees it).
- Inflight counter: +1 on read accept, -1 on FIFO push; simultaneous events net to 0. Writes produce no response and do not count.
- req_bank >= N_SRAM: request is accepted and no enables are driven. A read still returns rsp_data = 0 with normal latency.
- FIFO contents remain poppable in DRAIN/SLEEP/WAKE.
- pwr_sd_req/pwr_ds_req changing while in SLEEP: sram_sd/ds follow one cycle later, pwr_ack stays 1.
- Reset mid-operation: inflight reads and FIFO contents are discarded; no rsp_valid until new reads are accepted.

Test Plan:
- Release reset, hold req_valid: req_ready = 0 for 4 cycles (WAKE_CYC = 4), then 1. Write bank 2, addr 0x3A, data 0xC5, mask 4'b1111 -> next cycle sram_wrte_en = 4'b0100, sram_ck_en = 4'b0100, sram_addr = 0x3A.
- Read bank 1 addr 0x05, model returns 0x5A on bank 1 -> sram_read_en = 4'b0010 one cycle after accept; rsp_valid with rsp_data = 0x5A exactly 2 cycles after accept (RD_LAT = 1).
- 10 back-to-back reads alternating banks 0/3 with rsp_ready = 1 -> one accept per cycle; responses in order with matching data.
- rsp_ready = 0 with continuous reads -> exactly 3 reads accepted, then req_ready = 0. Raising rsp_ready drains the 3 responses in order and accepts resume.
- Two reads in flight, raise pwr_ds_req -> req_ready drops immediately; both responses still delivered; sram_ds = 1 and pwr_ack = 1 after drain. Drop pwr_ds_req -> sram_ds = 0, then 4 WAKE cycles before req_ready = 1.
- Assert rst_n = 0 while reads are in flight and the FIFO is non-empty -> outputs 0 asynchronously; no stale rsp_valid after release.

Source files
------------

// File: rtl/nl2_scm_dbank_sram_ctrl.sv
// Access sequencer for the SCM data-bank SRAM array: registered request issue,
// one-hot bank enables, credit-protected read-response FIFO and sd/ds power sequencing.
module nl2_scm_dbank_sram_ctrl #(
    parameter int unsigned ADDR_SIZE  = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MASK_WIDTH = 1,
    parameter int unsigned N_NARROW   = 4,
    parameter int unsigned N_SRAM     = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned WAKE_CYC   = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         req_valid,
    output logic                                         req_ready,
    input  logic                                         req_write,
    input  logic [((N_SRAM > 1) ? $clog2(N_SRAM) : 1)-1:0] req_bank,
    input  logic [ADDR_SIZE-1:0]                         req_addr,
    input  logic [DATA_WIDTH-1:0]                        req_data,
    input  logic [N_NARROW*MASK_WIDTH-1:0]               req_mask,
    output logic                                         rsp_valid,
    input  logic                                         rsp_ready,
    output logic [DATA_WIDTH-1:0]                        rsp_data,
    input  logic                                         pwr_sd_req,
    input  logic                                         pwr_ds_req,
    output logic                                         pwr_ack,
    output logic [N_SRAM-1:0]                            sram_ck_en,
    output logic                                         sram_sd,
    output logic                                         sram_ds,
    output logic [ADDR_SIZE-1:0]                         sram_addr,
    output logic [DATA_WIDTH-1:0]                        sram_data_wr,
    output logic [N_NARROW*MASK_WIDTH-1:0]               sram_mask,
    output logic [N_SRAM-1:0]                            sram_read_en,
    output logic [N_SRAM-1:0]                            sram_wrte_en,
    input  logic [N_SRAM*DATA_WIDTH-1:0]                 sram_data_rd
);

    localparam int unsigned BANK_W = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
    localparam int unsigned MASK_W = N_NARROW * MASK_WIDTH;
    localparam int unsigned DEPTH  = RD_LAT + 2;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned WAKE_W = $clog2(WAKE_CYC + 1);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [WAKE_W-1:0]       wake_cnt, wake_cnt_nx;
    logic [CNT_W-1:0]        fifo_cnt, fifo_cnt_nx;
    logic [CNT_W-1:0]        inflight, inflight_nx;
    logic [PTR_W-1:0]        wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx, rd_ptr_p1;
    logic [DATA_WIDTH-1:0]   fifo_mem [DEPTH];

    logic [RD_LAT:0]             pipe_vld, pipe_vld_nx;
    logic [RD_LAT:0]             pipe_ok, pipe_ok_nx;
    logic [RD_LAT:0][BANK_W-1:0] pipe_bank, pipe_bank_nx;

    logic                    req_ready_nx, rsp_valid_nx, pwr_ack_nx, sram_sd_nx, sram_ds_nx;
    logic [DATA_WIDTH-1:0]   rsp_data_nx, sram_data_wr_nx;
    logic [ADDR_SIZE-1:0]    sram_addr_nx;
    logic [MASK_W-1:0]       sram_mask_nx;
    logic [N_SRAM-1:0]       sram_read_en_nx, sram_wrte_en_nx, sram_ck_en_nx;

    logic                    accept_c, rd_accept_c, push_c, pop_c, bank_ok_c;
    logic [N_SRAM-1:0]       bank_oh_c;
    logic [DATA_WIDTH-1:0]   push_data_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Out-of-range banks only exist when N_SRAM is not a power of two
    generate
        if (N_SRAM == (1 << BANK_W)) begin : g_bank_full
            assign bank_ok_c = 1'b1;
        end else begin : g_bank_partial
            assign bank_ok_c = (32'(req_bank) < N_SRAM);
        end
    endgenerate

    always_comb begin
        bank_oh_c = '0;
        for (int unsigned i = 0; i < N_SRAM; i++) begin
            bank_oh_c[i] = bank_ok_c && (32'(req_bank) == i);
        end
    end

    // Read data of the bank at the last pipe stage; invalid banks return zero
    always_comb begin
        push_data_c = '0;
        for (int unsigned i = 0; i < N_SRAM; i++) begin
            if (pipe_ok[RD_LAT] && (32'(pipe_bank[RD_LAT]) == i)) begin
                push_data_c = sram_data_rd[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        wake_cnt_nx = wake_cnt;

        accept_c    = req_valid & req_ready;
        rd_accept_c = accept_c & ~req_write;
        push_c      = pipe_vld[RD_LAT];
        pop_c       = rsp_valid & rsp_ready;

        case (state)
            ST_ACTIVE: begin
                if (pwr_sd_req || pwr_ds_req) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pwr_sd_req && !pwr_ds_req) state_nx = ST_ACTIVE;
                else if (inflight == '0)        state_nx = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (!pwr_sd_req && !pwr_ds_req) begin
                    state_nx    = ST_WAKE;
                    wake_cnt_nx = WAKE_W'(WAKE_CYC);
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_W'(1)) state_nx = ST_ACTIVE;
                else                        wake_cnt_nx = wake_cnt - WAKE_W'(1);
            end
            default: state_nx = ST_WAKE;
        endcase

        fifo_cnt_nx = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
        inflight_nx = inflight + CNT_W'(rd_accept_c) - CNT_W'(push_c);
        wr_ptr_nx   = push_c ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_p1   = ptr_inc(rd_ptr);
        rd_ptr_nx   = pop_c ? rd_ptr_p1 : rd_ptr;

        pipe_vld_nx  = {pipe_vld[RD_LAT-1:0], rd_accept_c};
        pipe_ok_nx   = {pipe_ok[RD_LAT-1:0], rd_accept_c & bank_ok_c};
        pipe_bank_nx = {pipe_bank[RD_LAT-1:0], req_bank};

        // Head register tracks the entry that will sit at rd_ptr after this edge
        rsp_data_nx = rsp_data;
        if (pop_c) begin
            rsp_data_nx = (fifo_cnt > CNT_W'(1)) ? fifo_mem[rd_ptr_p1] : push_data_c;
        end else if (fifo_cnt == '0) begin
            rsp_data_nx = push_data_c;
        end
        rsp_valid_nx = (fifo_cnt_nx != '0);

        req_ready_nx = (state_nx == ST_ACTIVE) &&
                       ((CNT_W+1)'(fifo_cnt_nx) + (CNT_W+1)'(inflight_nx) < (CNT_W+1)'(DEPTH));

        sram_addr_nx    = accept_c ? req_addr : sram_addr;
        sram_data_wr_nx = accept_c ? req_data : sram_data_wr;
        sram_mask_nx    = accept_c ? req_mask : sram_mask;
        sram_read_en_nx = rd_accept_c ? bank_oh_c : '0;
        sram_wrte_en_nx = (accept_c && req_write) ? bank_oh_c : '0;
        sram_ck_en_nx   = sram_read_en_nx | sram_wrte_en_nx;

        pwr_ack_nx = (state_nx == ST_SLEEP);
        sram_sd_nx = (state_nx == ST_SLEEP) && pwr_sd_req;
        sram_ds_nx = (state_nx == ST_SLEEP) && pwr_ds_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_WAKE;
            wake_cnt     <= WAKE_W'(WAKE_CYC);
            fifo_cnt     <= '0;
            inflight     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pipe_vld     <= '0;
            pipe_ok      <= '0;
            pipe_bank    <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            pwr_ack      <= 1'b0;
            sram_sd      <= 1'b0;
            sram_ds      <= 1'b0;
            sram_addr    <= '0;
            sram_data_wr <= '0;
            sram_mask    <= '0;
            sram_read_en <= '0;
            sram_wrte_en <= '0;
            sram_ck_en   <= '0;
        end else begin
            state        <= state_nx;
            wake_cnt     <= wake_cnt_nx;
            fifo_cnt     <= fifo_cnt_nx;
            inflight     <= inflight_nx;
            wr_ptr       <= wr_ptr_nx;
            rd_ptr       <= rd_ptr_nx;
            pipe_vld     <= pipe_vld_nx;
            pipe_ok      <= pipe_ok_nx;
            pipe_bank    <= pipe_bank_nx;
            req_ready    <= req_ready_nx;
            rsp_valid    <= rsp_valid_nx;
            rsp_data     <= rsp_data_nx;
            pwr_ack      <= pwr_ack_nx;
            sram_sd      <= sram_sd_nx;
            sram_ds      <= sram_ds_nx;
            sram_addr    <= sram_addr_nx;
            sram_data_wr <= sram_data_wr_nx;
            sram_mask    <= sram_mask_nx;
            sram_read_en <= sram_read_en_nx;
            sram_wrte_en <= sram_wrte_en_nx;
            sram_ck_en   <= sram_ck_en_nx;
        end
    end

    // Storage needs no reset; occupancy is tracked by fifo_cnt
    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= push_data_c;
    end

endmodule

// File: tb/tb_nl2_scm_dbank_sram_ctrl.sv
// Directed bench for nl2_scm_dbank_sram_ctrl: wake timing, bank decode, read latency,
// credit backpressure, power drain/sleep/wake and mid-operation reset.
module tb_nl2_scm_dbank_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_bank;
    logic [9:0]  req_addr;
    logic [7:0]  req_data;
    logic [3:0]  req_mask;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        pwr_sd_req, pwr_ds_req, pwr_ack;
    logic [3:0]  sram_ck_en, sram_read_en, sram_wrte_en, sram_mask;
    logic        sram_sd, sram_ds;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_data_wr;
    logic [31:0] sram_data_rd;

    int          n_vec = 0;
    int          n_miscmp = 0;
    int          acc_rd = 0;
    int          rsp_seen = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    nl2_scm_dbank_sram_ctrl #(
        .ADDR_SIZE(10), .DATA_WIDTH(8), .MASK_WIDTH(1), .N_NARROW(4),
        .N_SRAM(4), .RD_LAT(1), .WAKE_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_bank(req_bank), .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .pwr_sd_req(pwr_sd_req), .pwr_ds_req(pwr_ds_req), .pwr_ack(pwr_ack),
        .sram_ck_en(sram_ck_en), .sram_sd(sram_sd), .sram_ds(sram_ds),
        .sram_addr(sram_addr), .sram_data_wr(sram_data_wr), .sram_mask(sram_mask),
        .sram_read_en(sram_read_en), .sram_wrte_en(sram_wrte_en),
        .sram_data_rd(sram_data_rd)
    );

    function automatic logic [7:0] model(input int b, input logic [9:0] a);
        if (b == 1 && a == 10'h005) return 8'h5A;
        return a[7:0] ^ 8'(b << 6) ^ 8'h33;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic w, input logic [1:0] b,
                             input logic [9:0] a, input logic [7:0] d, input logic [3:0] m);
        req_valid = v;
        req_write = w;
        req_bank  = b;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
    endtask

    // Single-cycle-latency SRAM array model
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (sram_read_en[b]) sram_data_rd[b*8 +: 8] <= model(b, sram_addr);
        end
    end

    // Scoreboard: record read accepts, compare responses in order
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (req_valid && req_ready && !req_write) begin
                acc_rd++;
                exp_q.push_back(model(int'(req_bank), req_addr));
            end
            if (rsp_valid && rsp_ready) begin
                rsp_seen++;
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else                   check("rsp_data_order", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic rdy;

        sram_data_rd = '0;
        rst_n = 1'b1;
        drive_req(1'b0, 1'b0, 2'd0, 10'd0, 8'd0, 4'd0);
        rsp_ready  = 1'b0;
        pwr_sd_req = 1'b0;
        pwr_ds_req = 1'b0;
        #2 rst_n = 1'b0;
        cyc();
        cyc();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ck_en", 32'(sram_ck_en), 32'd0);
        check("rst_pwr_ack", 32'(pwr_ack), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);

        // Wake after reset, then a write to bank 2
        rst_n = 1'b1;
        drive_req(1'b1, 1'b1, 2'd2, 10'h03A, 8'hC5, 4'hF);
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        check("wake_cycles", 32'(n), 32'd4);
        cyc();
        req_valid = 1'b0;
        check("wr_wrte_en", 32'(sram_wrte_en), 32'h4);
        check("wr_ck_en", 32'(sram_ck_en), 32'h4);
        check("wr_read_en", 32'(sram_read_en), 32'h0);
        check("wr_addr", 32'(sram_addr), 32'h3A);
        check("wr_data", 32'(sram_data_wr), 32'hC5);
        check("wr_mask", 32'(sram_mask), 32'hF);
        cyc();
        check("idle_wrte_en", 32'(sram_wrte_en), 32'h0);
        check("idle_ck_en", 32'(sram_ck_en), 32'h0);
        check("idle_addr_hold", 32'(sram_addr), 32'h3A);

        // Single read, bank 1 addr 5: two-cycle response latency
        rsp_ready = 1'b1;
        drive_req(1'b1, 1'b0, 2'd1, 10'h005, 8'h00, 4'h0);
        cyc();
        req_valid = 1'b0;
        check("rd_read_en", 32'(sram_read_en), 32'h2);
        check("rd_ck_en", 32'(sram_ck_en), 32'h2);
        check("rd_lat_c1", 32'(rsp_valid), 32'd0);
        cyc();
        check("rd_lat_c2", 32'(rsp_valid), 32'd0);
        cyc();
        check("rd_lat_valid", 32'(rsp_valid), 32'd1);
        check("rd_lat_data", 32'(rsp_data), 32'h5A);
        repeat (3) cyc();

        // Ten reads alternating banks 0/3 with rsp_ready held
        base = rsp_seen;
        for (int i = 0; i < 10; i++) begin
            drive_req(1'b1, 1'b0, (i % 2 != 0) ? 2'd3 : 2'd0, 10'(16 + i * 5), 8'h00, 4'h0);
            n = 0;
            do begin
                rdy = req_ready;
                cyc();
                n++;
            end while (!rdy && n < 20);
            if (!rdy) check("b2b_accept_timeout", 32'(rdy), 32'd1);
        end
        req_valid = 1'b0;
        repeat (6) cyc();
        check("b2b_rsp_count", 32'(rsp_seen - base), 32'd10);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: credits allow exactly three reads
        rsp_ready = 1'b0;
        base = acc_rd;
        for (int i = 0; i < 8; i++) begin
            drive_req(1'b1, 1'b0, 2'(i), 10'(100 + i), 8'h00, 4'h0);
            cyc();
        end
        check("bp_accepts", 32'(acc_rd - base), 32'd3);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        base = rsp_seen;
        repeat (6) cyc();
        check("bp_drained", 32'(rsp_seen - base), 32'd3);
        check("bp_ready_back", 32'(req_ready), 32'd1);

        // Two reads in flight, then deep-sleep request
        base = rsp_seen;
        drive_req(1'b1, 1'b0, 2'd2, 10'h011, 8'h00, 4'h0);
        cyc();
        drive_req(1'b1, 1'b0, 2'd3, 10'h022, 8'h00, 4'h0);
        cyc();
        req_valid  = 1'b0;
        pwr_ds_req = 1'b1;
        cyc();
        check("pwr_ready_drop", 32'(req_ready), 32'd0);
        n = 1;
        while (!pwr_ack && n < 10) begin
            cyc();
            n++;
        end
        check("drain_cycles", 32'(n), 32'd3);
        check("sleep_ds", 32'(sram_ds), 32'd1);
        check("sleep_sd", 32'(sram_sd), 32'd0);
        check("sleep_ready", 32'(req_ready), 32'd0);
        check("drain_rsps", 32'(rsp_seen - base), 32'd2);
        pwr_sd_req = 1'b1;
        cyc();
        check("sleep_sd_follow", 32'(sram_sd), 32'd1);
        check("sleep_ack_hold", 32'(pwr_ack), 32'd1);
        pwr_sd_req = 1'b0;
        pwr_ds_req = 1'b0;
        cyc();
        check("wake_ds_low", 32'(sram_ds), 32'd0);
        check("wake_sd_low", 32'(sram_sd), 32'd0);
        check("wake_ack_low", 32'(pwr_ack), 32'd0);
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        check("wake_after_sleep", 32'(n), 32'd4);

        // Reset with reads in flight and FIFO occupied
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 1'b0, 2'(i + 1), 10'(200 + i), 8'h00, 4'h0);
            cyc();
        end
        req_valid = 1'b0;
        check("prerst_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_read_en", 32'(sram_read_en), 32'd0);
        check("arst_ck_en", 32'(sram_ck_en), 32'd0);
        check("arst_addr", 32'(sram_addr), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        repeat (8) begin
            cyc();
            if (rsp_valid) n++;
        end
        check("no_stale_rsp", 32'(n), 32'd0);
        check("ready_after_rst", 32'(req_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
